// File: rtl/bram_arbiter.sv
// Shares a single-port BRAM between the Wishbone slave and a local engine port.
// Decodes the Wishbone address window, arbitrates round-robin and times the read latency.
module bram_arbiter #(
    parameter int unsigned ADDR_W    = 15,
    parameter int unsigned RD_LAT    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h3800_0000,
    parameter logic [31:0] WIN_SIZE  = 32'h0040_0000
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    input  logic              eng_req,
    input  logic              eng_we,
    input  logic [ADDR_W-1:0] eng_adr,
    input  logic [31:0]       eng_wdat,
    output logic              eng_ack,
    output logic [31:0]       eng_rdat,
    output logic              bram_en,
    output logic [3:0]        bram_we,
    output logic [ADDR_W+1:0] bram_a,
    output logic [31:0]       bram_di,
    input  logic [31:0]       bram_do,
    output logic              busy
);

    localparam int unsigned CNT_W = 4;
    localparam logic [32:0] WIN_END = 33'(BASE_ADDR) + 33'(WIN_SIZE);
    localparam logic OWN_WB  = 1'b0;
    localparam logic OWN_ENG = 1'b1;

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_e;

    state_e             state_q, state_d;
    logic               last_q, last_d;
    logic               owner_q, owner_d;
    logic               wr_q, wr_d;
    logic               oow_q, oow_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               en_d, wack_d, eack_d, busy_d;
    logic [3:0]         we_d;
    logic [ADDR_W+1:0]  a_d;
    logic [31:0]        di_d, wdat_d, erdat_d;

    logic               wb_req_c;
    logic               in_win_c;
    logic [ADDR_W-1:0]  wb_word_c;
    logic               pick_c;

    assign wb_req_c  = wbs_stb_i & wbs_cyc_i;
    assign in_win_c  = (wbs_adr_i >= BASE_ADDR) && (33'(wbs_adr_i) < WIN_END);
    assign wb_word_c = ADDR_W'((wbs_adr_i - BASE_ADDR) >> 2);
    assign pick_c    = (wb_req_c & eng_req) ? ~last_q : (wb_req_c ? OWN_WB : OWN_ENG);

    // Next-state and next-output logic; pulses and BRAM strobes default to 0.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        wr_d    = wr_q;
        oow_d   = oow_q;
        cnt_d   = cnt_q;
        en_d    = 1'b0;
        we_d    = 4'h0;
        a_d     = '0;
        di_d    = 32'h0;
        wack_d  = 1'b0;
        eack_d  = 1'b0;
        wdat_d  = wbs_dat_o;
        erdat_d = eng_rdat;
        case (state_q)
            IDLE: begin
                if (wb_req_c | eng_req) begin
                    owner_d = pick_c;
                    last_d  = pick_c;
                    state_d = ACCESS;
                    if (pick_c == OWN_WB) begin
                        wr_d  = wbs_we_i;
                        oow_d = ~in_win_c;
                        if (in_win_c) begin
                            en_d = 1'b1;
                            a_d  = {wb_word_c, 2'b00};
                            if (wbs_we_i) begin
                                we_d = wbs_sel_i;
                                di_d = wbs_dat_i;
                            end
                        end
                    end else begin
                        wr_d  = eng_we;
                        oow_d = 1'b0;
                        en_d  = 1'b1;
                        a_d   = {eng_adr, 2'b00};
                        if (eng_we) begin
                            we_d = 4'hF;
                            di_d = eng_wdat;
                        end
                    end
                end
            end
            ACCESS: begin
                if (wr_q | oow_q) begin
                    state_d = RESP;
                    if (owner_q == OWN_WB) wack_d = 1'b1;
                    else                   eack_d = 1'b1;
                    if (oow_q && !wr_q)    wdat_d = 32'h0;
                end else begin
                    state_d = WAIT;
                    cnt_d   = CNT_W'(RD_LAT - 1);
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    if (owner_q == OWN_WB) begin
                        wack_d = 1'b1;
                        wdat_d = bram_do;
                    end else begin
                        eack_d  = 1'b1;
                        erdat_d = bram_do;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_q   <= IDLE;
            last_q    <= OWN_ENG;
            owner_q   <= OWN_WB;
            wr_q      <= 1'b0;
            oow_q     <= 1'b0;
            cnt_q     <= '0;
            bram_en   <= 1'b0;
            bram_we   <= 4'h0;
            bram_a    <= '0;
            bram_di   <= 32'h0;
            wbs_ack_o <= 1'b0;
            eng_ack   <= 1'b0;
            wbs_dat_o <= 32'h0;
            eng_rdat  <= 32'h0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            owner_q   <= owner_d;
            wr_q      <= wr_d;
            oow_q     <= oow_d;
            cnt_q     <= cnt_d;
            bram_en   <= en_d;
            bram_we   <= we_d;
            bram_a    <= a_d;
            bram_di   <= di_d;
            wbs_ack_o <= wack_d;
            eng_ack   <= eack_d;
            wbs_dat_o <= wdat_d;
            eng_rdat  <= erdat_d;
            busy      <= busy_d;
        end
    end

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter: vector table of single transactions plus
// arbitration and mid-transaction reset sequences, against a latency-accurate BRAM model.
module tb_bram_arbiter;

    localparam int RD_LAT = 10;
    localparam int RLAT   = RD_LAT + 2;

    logic        clk, rst_n;
    logic        wbs_stb_i, wbs_cyc_i, wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i, wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        eng_req, eng_we;
    logic [14:0] eng_adr;
    logic [31:0] eng_wdat;
    logic        eng_ack;
    logic [31:0] eng_rdat;
    logic        bram_en;
    logic [3:0]  bram_we;
    logic [16:0] bram_a;
    logic [31:0] bram_di, bram_do;
    logic        busy;

    int n_chk = 0;
    int n_err = 0;

    bram_arbiter dut (
        .wb_clk_i(clk), .wb_rst_i(rst_n),
        .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .eng_req(eng_req), .eng_we(eng_we), .eng_adr(eng_adr), .eng_wdat(eng_wdat),
        .eng_ack(eng_ack), .eng_rdat(eng_rdat),
        .bram_en(bram_en), .bram_we(bram_we), .bram_a(bram_a), .bram_di(bram_di),
        .bram_do(bram_do), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM model: byte-enable writes, read data valid exactly RD_LAT cycles after enable.
    logic [31:0] mem [0:32767];
    logic [31:0] pipe_d [0:RD_LAT-1];
    logic        pipe_v [0:RD_LAT-1];
    initial for (int i = 0; i < RD_LAT; i++) pipe_v[i] = 1'b0;
    always @(posedge clk) begin
        if (bram_en && bram_we != 4'h0)
            for (int b = 0; b < 4; b++)
                if (bram_we[b]) mem[bram_a[16:2]][8*b +: 8] <= bram_di[8*b +: 8];
        pipe_d[0] <= mem[bram_a[16:2]];
        pipe_v[0] <= bram_en && (bram_we == 4'h0);
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_d[i] <= pipe_d[i-1];
            pipe_v[i] <= pipe_v[i-1];
        end
    end
    assign bram_do = pipe_v[RD_LAT-1] ? pipe_d[RD_LAT-1] : 32'hA5A5_A5A5;

    typedef struct {
        bit          src;   // 0 = Wishbone, 1 = engine
        bit          we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
        int          lat;
        int          en;
        logic [16:0] a;
        logic [3:0]  bwe;
        logic [31:0] di;
        logic [31:0] rd;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drop_all();
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0; wbs_sel_i = 4'h0;
        wbs_adr_i = 32'h0; wbs_dat_i = 32'h0;
        eng_req = 1'b0; eng_we = 1'b0; eng_adr = 15'h0; eng_wdat = 32'h0;
    endtask

    // Called just after a rising edge with the DUT idle; that cycle is cycle 0.
    task automatic run_txn(input vec_t v, output int lat, output int en_cnt,
                           output logic [16:0] a_s, output logic [3:0] we_s,
                           output logic [31:0] di_s, output logic [31:0] rd,
                           output bit other, output bit stray);
        lat = -1; en_cnt = 0; a_s = '0; we_s = 4'h0; di_s = 32'h0; rd = 32'h0;
        other = 1'b0; stray = 1'b0;
        if (v.src == 1'b0) begin
            wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = v.we;
            wbs_sel_i = v.sel; wbs_adr_i = v.adr; wbs_dat_i = v.dat;
        end else begin
            eng_req = 1'b1; eng_we = v.we; eng_adr = v.adr[14:0]; eng_wdat = v.dat;
        end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bram_en) begin
                en_cnt++; a_s = bram_a; we_s = bram_we; di_s = bram_di;
            end else if (bram_a != 17'h0 || bram_we != 4'h0 || bram_di != 32'h0) begin
                stray = 1'b1;
            end
            if (v.src == 1'b0 ? eng_ack : wbs_ack_o) other = 1'b1;
            if (v.src == 1'b0 ? wbs_ack_o : eng_ack) begin
                lat = c;
                rd  = (v.src == 1'b0) ? wbs_dat_o : eng_rdat;
                break;
            end
        end
        @(posedge clk); #1;
        drop_all();
    endtask

    int          lat, en_cnt;
    logic [16:0] a_s;
    logic [3:0]  we_s;
    logic [31:0] di_s, rd;
    bit          other, stray;
    int          ack_cyc [4];
    int          ack_src [4];
    int          n_ack;
    bit          both_ack;
    vec_t        rv;

    initial begin
        //            src   we    sel   adr            dat            lat   en a         bwe   di             rd
        vecs[0] = '{1'b0, 1'b1, 4'hF, 32'h3800_0010, 32'hDEAD_BEEF, 2,    1, 17'h00010, 4'hF, 32'hDEAD_BEEF, 32'h0};
        vecs[1] = '{1'b0, 1'b0, 4'hF, 32'h3800_0010, 32'h0,         RLAT, 1, 17'h00010, 4'h0, 32'h0,         32'hDEAD_BEEF};
        vecs[2] = '{1'b0, 1'b0, 4'hF, 32'h3840_0000, 32'h0,         2,    0, 17'h0,     4'h0, 32'h0,         32'h0};
        vecs[3] = '{1'b0, 1'b0, 4'hF, 32'h3000_0000, 32'h0,         2,    0, 17'h0,     4'h0, 32'h0,         32'h0};
        vecs[4] = '{1'b1, 1'b1, 4'hF, 32'h0000_7FFF, 32'h1234_5678, 2,    1, 17'h1FFFC, 4'hF, 32'h1234_5678, 32'h0};
        vecs[5] = '{1'b0, 1'b0, 4'hF, 32'h3801_FFFC, 32'h0,         RLAT, 1, 17'h1FFFC, 4'h0, 32'h0,         32'h1234_5678};
        vecs[6] = '{1'b0, 1'b1, 4'h3, 32'h3800_0010, 32'hCAFE_1234, 2,    1, 17'h00010, 4'h3, 32'hCAFE_1234, 32'h0};
        vecs[7] = '{1'b1, 1'b0, 4'hF, 32'h0000_0004, 32'h0,         RLAT, 1, 17'h00010, 4'h0, 32'h0,         32'hDEAD_1234};
        vecs[8] = '{1'b0, 1'b1, 4'hF, 32'h37FF_FFFC, 32'hFFFF_FFFF, 2,    0, 17'h0,     4'h0, 32'h0,         32'h0};
        vecs[9] = '{1'b0, 1'b0, 4'hF, 32'h383F_FFFC, 32'h0,         RLAT, 1, 17'h1FFFC, 4'h0, 32'h0,         32'h1234_5678};

        rst_n = 1'b0;
        drop_all();
        @(posedge clk); #1;
        chk("reset_outputs", {15'h0, wbs_ack_o, eng_ack, busy, bram_en, bram_we, bram_a[16:8]}, 32'h0);
        chk("reset_low_a", {24'h0, bram_a[7:0]}, 32'h0);
        chk("reset_wbs_dat", wbs_dat_o, 32'h0);
        chk("reset_eng_rdat", eng_rdat, 32'h0);
        chk("reset_bram_di", bram_di, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Both requesters reading continuously from reset: WB first, then alternate.
        for (int i = 0; i < 4; i++) begin ack_cyc[i] = -1; ack_src[i] = -1; end
        n_ack = 0; both_ack = 1'b0;
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'h3800_0010;
        eng_req = 1'b1; eng_we = 1'b0; eng_adr = 15'h0004;
        for (int c = 0; c < 80 && n_ack < 4; c++) begin
            @(negedge clk);
            if (wbs_ack_o && eng_ack) both_ack = 1'b1;
            if (wbs_ack_o) begin ack_cyc[n_ack] = c; ack_src[n_ack] = 0; n_ack++; end
            else if (eng_ack) begin ack_cyc[n_ack] = c; ack_src[n_ack] = 1; n_ack++; end
        end
        @(posedge clk); #1;
        drop_all();
        chk("rr_both_ack", 32'(both_ack), 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rr_owner%0d", i), 32'(ack_src[i]), 32'(i % 2));
            chk($sformatf("rr_cycle%0d", i), 32'(ack_cyc[i]), 32'(RLAT + i * (RLAT + 1)));
        end

        // Single-transaction vectors.
        for (int i = 0; i < 10; i++) begin
            run_txn(vecs[i], lat, en_cnt, a_s, we_s, di_s, rd, other, stray);
            chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("v%0d_en_cycles", i), 32'(en_cnt), 32'(vecs[i].en));
            chk($sformatf("v%0d_other_ack", i), 32'(other), 32'h0);
            chk($sformatf("v%0d_idle_bus", i), 32'(stray), 32'h0);
            if (vecs[i].en != 0) begin
                chk($sformatf("v%0d_bram_a", i), 32'(a_s), 32'(vecs[i].a));
                chk($sformatf("v%0d_bram_we", i), 32'(we_s), 32'(vecs[i].bwe));
                chk($sformatf("v%0d_bram_di", i), di_s, vecs[i].di);
            end
            if (!vecs[i].we) chk($sformatf("v%0d_rdata", i), rd, vecs[i].rd);
        end
        chk("eng_rdat_hold", eng_rdat, 32'hDEAD_1234);

        // Reset during WAIT of a WB read: outputs clear at once, no ack, then a fresh read works.
        rv = vecs[1];
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'h3800_0010;
        repeat (5) @(negedge clk);
        chk("pre_reset_busy", 32'(busy), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_ctrl", {23'h0, wbs_ack_o, eng_ack, busy, bram_en, bram_we, bram_a[16]}, 32'h0);
        chk("async_reset_wbs_dat", wbs_dat_o, 32'h0);
        chk("async_reset_eng_rdat", eng_rdat, 32'h0);
        other = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (wbs_ack_o || eng_ack || busy) other = 1'b1;
            if (c == 2) drop_all();
        end
        chk("no_ack_in_reset", 32'(other), 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_txn(rv, lat, en_cnt, a_s, we_s, di_s, rd, other, stray);
        chk("post_reset_lat", 32'(lat), 32'(RLAT));
        chk("post_reset_rdata", rd, 32'hDEAD_1234);
        chk("post_reset_en_cycles", 32'(en_cnt), 32'h1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/bram_arbiter.md
Name: bram_arbiter

Overview:
- Sequences and shares the single-port user BRAM between two requesters: the Wishbone slave interface (management SoC) and a local user engine port (for example a FIR or DMA engine).
- Performs address-window decoding, round-robin arbitration and read-latency timing.
- Returns a single-cycle acknowledge to the winning requester.
- Sits between the Wishbone bus and the `bram` macro inside `user_proj_example`, replacing ad-hoc delay counting.

Parameters:
- ADDR_W, 15, BRAM word-address width; the byte address to the BRAM is ADDR_W+2 bits.
- RD_LAT, 10, cycles from the BRAM enable cycle to valid Do0; legal range 1..15.
- BASE_ADDR, 32'h3800_0000, Wishbone window base (inclusive).
- WIN_SIZE, 32'h0040_0000, Wishbone window size in bytes; the window end is exclusive.

Ports:
- wb_clk_i  input  1  single clock, rising edge.
- wb_rst_i  input  1  reset, asynchronous assert, active-low (0 = reset).
- wbs_stb_i  input  1  Wishbone strobe.
- wbs_cyc_i  input  1  Wishbone cycle.
- wbs_we_i  input  1  Wishbone write enable.
- wbs_sel_i  input  4  Wishbone byte selects.
- wbs_adr_i  input  32  Wishbone byte address.
- wbs_dat_i  input  32  Wishbone write data.
- wbs_ack_o  output  1  Wishbone acknowledge, registered, 1-cycle pulse.
- wbs_dat_o  output  32  Wishbone read data, registered.
- eng_req  input  1  engine request; held high until eng_ack.
- eng_we  input  1  engine write (full word).
- eng_adr  input  ADDR_W  engine word address.
- eng_wdat  input  32  engine write data.
- eng_ack  output  1  engine acknowledge, registered, 1-cycle pulse.
- eng_rdat  output  32  engine read data, registered.
- bram_en  output  1  BRAM EN0.
- bram_we  output  4  BRAM WE0.
- bram_a  output  ADDR_W+2  BRAM byte address; bits [1:0] always 0.
- bram_di  output  32  BRAM Di0.
- bram_do  input  32  BRAM Do0.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (wb_rst_i=0, asynchronous):
  - state=IDLE, last_owner=ENG.
  - All outputs 0: wbs_ack_o, eng_ack, wbs_dat_o, eng_rdat, bram_en, bram_we, bram_a, bram_di, busy.
  - Reset mid-transaction aborts it with no ack; the requester must re-issue.
- WB request = wbs_stb_i & wbs_cyc_i. In-window = BASE_ADDR <= adr < BASE_ADDR+WIN_SIZE.
- WB word address = (adr-BASE_ADDR)>>2, truncated to ADDR_W bits.
- States are IDLE, ACCESS, WAIT and RESP.
- IDLE, on any request:
  - Choose the owner. With only one requester active, that requester wins. If both are active, the owner is the one opposite last_owner.
  - Update last_owner to the chosen owner and go to ACCESS.
  - Register the BRAM outputs so they are valid during ACCESS. For an out-of-window WB request, bram_en stays 0.
- ACCESS (exactly 1 cycle):
  - bram_en=1 and bram_a={word,2'b00}.
  - WB write: bram_we=wbs_sel_i, bram_di=wbs_dat_i.
  - Engine write: bram_we=4'b1111, bram_di=eng_wdat.
  - Read: bram_we=0.
  - Write or out-of-window access → RESP.
  - Read → WAIT with counter=RD_LAT-1. For RD_LAT=1 the counter starts at 0 and the read captures immediately.
- WAIT:
  - bram_en=0 and bram_we=0; the counter decrements.
  - When the counter reaches 0, capture bram_do (valid during cycle ACCESS+RD_LAT) into the owner's read-data register, then → RESP.
- RESP (1 cycle):
  - The owner's ack=1. The other ack is never asserted.
  - Out-of-window reads return 32'd0. Out-of-window writes are dropped.
  - Next state is IDLE.
- Latency, with the request first sampled in IDLE at cycle 0:
  - Write: ack at cycle 2.
  - Read: ack at cycle RD_LAT+2.
  - Minimum request-to-request spacing is 3 cycles (one IDLE bubble after RESP).
- Requests are sampled only in IDLE. Requester inputs changing during ACCESS/WAIT/RESP do not affect the current transaction; the ack is still issued.
- Read-data registers hold their value until the next read by the same owner.
- bram_a, bram_di and bram_we return to 0 outside ACCESS.

Test Plan:
- WB write 0x3800_0010 sel=4'hF data=0xDEADBEEF → bram_en=1, bram_a=0x10, bram_we=4'hF in ACCESS; wbs_ack_o high exactly at cycle 2.
- WB read 0x3800_0010 after the write, RD_LAT=10 → wbs_ack_o at cycle 12, wbs_dat_o=0xDEADBEEF; bram_en high exactly 1 cycle.
- WB read 0x3840_0000 (end, exclusive) and 0x3000_0000 → bram_en never 1; ack at cycle 2; data 0x0000_0000.
- WB and engine request simultaneously from reset, both reads → WB served first, engine next; eng_ack after wbs_ack_o plus IDLE bubble; repeat both continuously → grants alternate WB, ENG, WB, ENG.
- Engine write eng_adr=0x7FFF data=0x12345678, then WB read 0x3801_FFFC → bram_a=0x1FFFC both times, WB gets 0x12345678.
- Assert wb_rst_i=0 during WAIT of a read → all outputs 0 asynchronously, no ack; after release, a fresh request completes normally.
